quiz_buzzer_ctrl: RTL and testbench

Parametrised N-player quiz buzzer arbiter. It is the next generation of the fixed 8-switch answer-buzzer block and adds countdown timeout, deterministic tie-break, explicit state output and clear handshaking. It sits between the debounced start/clear/player inputs and the display/beeper path. It drives a winner ID, the remaining seconds and a beep pulse to the downstream display mux.

---
 rtl/quiz_buzzer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_quiz_buzzer_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/quiz_buzzer_ctrl.sv
// quiz_buzzer_ctrl: N-player quiz buzzer arbiter with countdown timeout, lowest-index tie-break and beep pulse.
// Define FALSE_START_EN to latch IDLE presses as fouls and mask that player in the next round.
module quiz_buzzer_ctrl #(
  parameter int N_PLAYERS   = 8,
  parameter int ID_W        = 4,
  parameter int SEC_CYCLES  = 50_000_000,
  parameter int COUNT_INIT  = 20,
  parameter int BEEP_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] player_btn,
  input  logic                 start_pulse,
  input  logic                 clear_pulse,
  output logic [1:0]           state_o,
  output logic                 winner_valid,
  output logic [ID_W-1:0]      winner_id,
  output logic [7:0]           count_sec,
  output logic                 beep,
  output logic                 foul_valid,
  output logic [ID_W-1:0]      foul_id
);

  localparam int PRE_W  = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PRE_W-1:0]     r_presc;
  logic [7:0]           r_count;
  logic [ID_W-1:0]      r_winner_id;
  logic [BEEP_W-1:0]    r_beep_cnt;
  logic [N_PLAYERS-1:0] w_live;
  logic                 w_any_live;
  logic [ID_W-1:0]      w_win_id;
  logic                 w_wrap;
  logic                 w_end_round;

`ifdef FALSE_START_EN
  logic                 r_foul_valid;
  logic [ID_W-1:0]      r_foul_id;
  logic [N_PLAYERS-1:0] r_mask;

  // Mask is zero until a foul is latched, so IDLE sees the raw buttons.
  assign w_live = player_btn & ~r_mask;
`else
  assign w_live = player_btn;
`endif

  assign w_any_live = |w_live;
  assign w_wrap     = (r_presc == PRE_W'(SEC_CYCLES - 1));

  always_comb begin
    logic w_found;
    w_found  = 1'b0;
    w_win_id = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (w_live[i] && !w_found) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_pulse) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (clear_pulse)                     w_state_nxt = S_IDLE;
        else if (w_any_live)                 w_state_nxt = S_LOCKED;
        else if (w_wrap && r_count == 8'd1)  w_state_nxt = S_TIMEOUT;
      end
      default: if (clear_pulse) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    state_o      = r_state;
    winner_valid = (r_state == S_LOCKED);
    winner_id    = r_winner_id;
    count_sec    = r_count;
    beep         = (r_beep_cnt != '0);
`ifdef FALSE_START_EN
    foul_valid   = r_foul_valid;
    foul_id      = r_foul_id;
`else
    foul_valid   = 1'b0;
    foul_id      = '0;
`endif
  end

  assign w_end_round = (r_state == S_ARMED) &&
                       ((w_state_nxt == S_LOCKED) || (w_state_nxt == S_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_count     <= 8'(COUNT_INIT);
      r_winner_id <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_pulse) begin
            r_presc <= '0;
            r_count <= 8'(COUNT_INIT);
          end
        end
        S_ARMED: begin
          if (clear_pulse) begin
            r_presc     <= '0;
            r_count     <= 8'(COUNT_INIT);
            r_winner_id <= '0;
          end else begin
            // A press on the wrap edge still takes the decrement, so 1->0 with a press locks at 0.
            r_presc <= w_wrap ? '0 : r_presc + PRE_W'(1);
            if (w_wrap && r_count != 8'd0) r_count <= r_count - 8'd1;
            if (w_any_live)                r_winner_id <= w_win_id;
          end
        end
        default: begin
          if (clear_pulse) begin
            r_count     <= 8'(COUNT_INIT);
            r_winner_id <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_beep_cnt <= '0;
    else if (clear_pulse)       r_beep_cnt <= '0;
    else if (w_end_round)       r_beep_cnt <= BEEP_W'(BEEP_CYCLES);
    else if (r_beep_cnt != '0)  r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
  end

`ifdef FALSE_START_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_foul_valid <= 1'b0;
      r_foul_id    <= '0;
      r_mask       <= '0;
    end else if (clear_pulse && r_state != S_IDLE) begin
      r_foul_valid <= 1'b0;
      r_foul_id    <= '0;
      r_mask       <= '0;
    end else if (r_state == S_IDLE && !r_foul_valid && w_any_live) begin
      r_foul_valid <= 1'b1;
      r_foul_id    <= w_win_id;
      r_mask       <= N_PLAYERS'(1) << (w_win_id - ID_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_quiz_buzzer_ctrl.sv
// Bench for quiz_buzzer_ctrl: directed scenarios then random traffic against a cycle-count based reference model.
module tb_quiz_buzzer_ctrl;
  localparam int NP    = 8;
  localparam int IDW   = 4;
  localparam int SEC   = 10;
  localparam int INIT  = 5;
  localparam int BEEPC = 7;
`ifdef FALSE_START_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] player_btn;
  logic          start_pulse, clear_pulse;
  logic [1:0]    state_o;
  logic          winner_valid, beep, foul_valid;
  logic [IDW-1:0] winner_id, foul_id;
  logic [7:0]    count_sec;

  int checks = 0;
  int errors = 0;

  // reference model: spec-level quantities, state numbers as the spec lists them
  int m_st, m_el, m_cnt, m_win, m_beep, m_fv, m_fid;

  quiz_buzzer_ctrl #(
    .N_PLAYERS(NP), .ID_W(IDW), .SEC_CYCLES(SEC), .COUNT_INIT(INIT), .BEEP_CYCLES(BEEPC)
  ) dut (
    .clk(clk), .rst(rst), .player_btn(player_btn), .start_pulse(start_pulse),
    .clear_pulse(clear_pulse), .state_o(state_o), .winner_valid(winner_valid),
    .winner_id(winner_id), .count_sec(count_sec), .beep(beep),
    .foul_valid(foul_valid), .foul_id(foul_id)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state_o), 32'(m_st));
    chk("winner_valid", 32'(winner_valid), 32'(m_st == 2));
    chk("winner_id", 32'(winner_id), 32'(m_win));
    chk("count_sec", 32'(count_sec), 32'(m_cnt));
    chk("beep", 32'(beep), 32'(m_beep > 0));
    chk("foul_valid", 32'(foul_valid), 32'(m_fv));
    chk("foul_id", 32'(foul_id), 32'(m_fid));
  endtask

  task automatic model_reset();
    m_st = 0; m_el = 0; m_cnt = INIT; m_win = 0; m_beep = 0; m_fv = 0; m_fid = 0;
  endtask

  task automatic model_edge(input logic [NP-1:0] btn, input logic st, input logic clr);
    logic [NP-1:0] live;
    if (m_beep > 0) m_beep--;
    if (clr) m_beep = 0;
    case (m_st)
      0: begin
        if (FS && m_fv == 0 && btn != 0) begin m_fv = 1; m_fid = lowest(btn); end
        if (st) begin m_st = 1; m_el = 0; m_cnt = INIT; end
      end
      1: begin
        if (clr) begin
          m_st = 0; m_cnt = INIT; m_win = 0; m_fv = 0; m_fid = 0;
        end else begin
          m_el++;
          m_cnt = INIT - m_el / SEC;
          live = btn;
          if (m_fv != 0) live[m_fid-1] = 1'b0;
          if (live != 0) begin m_st = 2; m_win = lowest(live); m_beep = BEEPC; end
          else if (m_cnt == 0) begin m_st = 3; m_beep = BEEPC; end
        end
      end
      default: begin
        if (clr) begin m_st = 0; m_cnt = INIT; m_win = 0; m_fv = 0; m_fid = 0; end
      end
    endcase
  endtask

  task automatic cyc(input logic [NP-1:0] btn, input logic st, input logic clr);
    player_btn = btn; start_pulse = st; clear_pulse = clr;
    @(posedge clk);
    model_edge(btn, st, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; player_btn = '0; start_pulse = 1'b0; clear_pulse = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // single press at cycle 23 after start
    cyc('0, 1'b1, 1'b0);
    idle(22);
    cyc(8'b0000_0100, 1'b0, 1'b0);
    chk("t1_state", 32'(state_o), 2);
    chk("t1_wid", 32'(winner_id), 3);
    chk("t1_count", 32'(count_sec), 3);
    chk("t1_beep", 32'(beep), 1);
    idle(BEEPC + 3);
    chk("t1_beep_end", 32'(beep), 0);
    cyc('0, 1'b0, 1'b1);

    // tie-break and late press ignored
    cyc('0, 1'b1, 1'b0);
    idle(3);
    cyc(8'b1001_0010, 1'b0, 1'b0);
    chk("t2_wid", 32'(winner_id), 2);
    cyc(8'b1000_0000, 1'b0, 1'b1 ^ 1'b1);
    chk("t2_wid_hold", 32'(winner_id), 2);
    cyc('0, 1'b0, 1'b1);

    // timeout
    cyc('0, 1'b1, 1'b0);
    idle(60);
    chk("t3_state", 32'(state_o), 3);
    chk("t3_count", 32'(count_sec), 0);
    chk("t3_wid", 32'(winner_id), 0);
    cyc('0, 1'b1, 1'b0);
    chk("t3_start_ignored", 32'(state_o), 3);
    cyc('0, 1'b0, 1'b1);

    // press on the 1->0 edge
    cyc('0, 1'b1, 1'b0);
    idle(49);
    cyc(8'b0000_0001, 1'b0, 1'b0);
    chk("t4_state", 32'(state_o), 2);
    chk("t4_count", 32'(count_sec), 0);
    chk("t4_wid", 32'(winner_id), 1);
    cyc('0, 1'b0, 1'b1);

    // async reset mid-ARMED, mid-beep; clear beats press
    cyc('0, 1'b1, 1'b0);
    idle(17);
    do_reset();
    chk("t5_state_rst", 32'(state_o), 0);
    chk("t5_count_rst", 32'(count_sec), INIT);
    cyc('0, 1'b1, 1'b0);
    idle(5);
    cyc(8'b0001_0000, 1'b0, 1'b0);
    idle(2);
    do_reset();
    chk("t5_beep_rst", 32'(beep), 0);
    cyc('0, 1'b1, 1'b0);
    idle(3);
    cyc(8'b0000_0100, 1'b0, 1'b1);
    chk("t5_clear_state", 32'(state_o), 0);
    chk("t5_clear_wid", 32'(winner_id), 0);

    // false start
    cyc(8'b0000_0001, 1'b0, 1'b0);
    chk("t6_fvalid", 32'(foul_valid), 32'(FS));
    chk("t6_fid", 32'(foul_id), FS ? 1 : 0);
    cyc('0, 1'b1, 1'b0);
    cyc(8'b0000_0011, 1'b0, 1'b0);
    chk("t6_wid", 32'(winner_id), FS ? 2 : 1);
    cyc('0, 1'b0, 1'b1);
    chk("t6_fclear", 32'(foul_valid), 0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc(($urandom_range(0, 9) == 0) ? NP'($urandom) : '0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
